// File: rtl/phy_pkg.sv
// phy_pkg -- constants and types shared by the PHY transmit and receive sides.
//   COM_SYM            : comma/sync symbol, sent MSB first
//   SYNC_SYMBOLS       : COM symbols sent after reset before any payload
//   WORD_BITS_PER_LANE : payload bits each lane carries per 32-bit word
//   tx_state_e         : serializer state
package phy_pkg;

  localparam logic [7:0] COM_SYM            = 8'hBC;
  localparam int         SYNC_SYMBOLS       = 4;
  localparam int         WORD_BITS_PER_LANE = 16;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    DATA = 2'd2
  } tx_state_e;

endpackage

// File: rtl/phy_tx_lane.sv
// phy_tx_lane -- one serial lane: 16-bit load/shift register with a registered
// serial output. When neither loading nor shifting, the lane sends com_bit_i.
//   clk_i     : bit clock
//   rst_ni    : synchronous active-low reset
//   load_i    : capture word_i; its MSB goes out on this same edge
//   shift_i   : send the next stored bit
//   word_i    : payload for this lane, MSB first
//   com_bit_i : filler bit sent when the lane carries no payload
//   ser_o     : registered serial output
module phy_tx_lane
  import phy_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          load_i,
  input  logic                          shift_i,
  input  logic [WORD_BITS_PER_LANE-1:0] word_i,
  input  logic                          com_bit_i,
  output logic                          ser_o
);

  localparam int W = WORD_BITS_PER_LANE;

  logic [W-1:0] sr_q, sr_d;
  logic         ser_q, ser_d;

  always_comb begin
    sr_d  = sr_q;
    ser_d = com_bit_i;
    if (load_i) begin
      // MSB leaves immediately; the register keeps the remaining bits.
      ser_d = word_i[W-1];
      sr_d  = {word_i[W-2:0], 1'b0};
    end else if (shift_i) begin
      ser_d = sr_q[W-1];
      sr_d  = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      ser_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      ser_q <= ser_d;
    end
  end

  assign ser_o = ser_q;

endmodule

// File: rtl/phy_tx.sv
// phy_tx -- two-lane serializer with a one-entry holding buffer.
// After reset it sends SYNC_SYMBOLS COM symbols, then at every 8-bit symbol
// boundary it either starts a buffered word (16 bits per lane) or sends COM.
//   clk_32f    : bit clock
//   reset      : synchronous active-low reset
//   data_in    : word to transmit
//   valid_in   : data_in valid; accepted when ready is high
//   ready      : holding buffer empty
//   data_out_0 : lane 0, data[31:24] then data[15:8], MSB first
//   data_out_1 : lane 1, data[23:16] then data[7:0], MSB first
//   active     : lanes carry payload bits
module phy_tx
  import phy_pkg::*;
(
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready,
  output logic        data_out_0,
  output logic        data_out_1,
  output logic        active
);

  localparam logic [2:0] SYNC_SYMS = 3'(SYNC_SYMBOLS);
  localparam logic [2:0] DATA_SYMS = 3'(WORD_BITS_PER_LANE / 8);

  tx_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;     // bit position within the current symbol
  logic [2:0]  sym_q, sym_d;     // symbols started in the current state
  logic        full_q, full_d;
  logic [31:0] buf_q, buf_d;
  logic        active_q, active_d;

  logic        accept, boundary, pick, load, shift, com_bit;

  assign ready    = reset & ~full_q;
  assign accept   = valid_in & ready;
  assign boundary = (cnt_q == 3'd0);
  assign com_bit  = COM_SYM[3'd7 - cnt_q];

  // The symbol decision is taken on the boundary edge itself, so a word
  // buffered on the edge just before a boundary still makes that boundary.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q + 3'd1;
    full_d  = full_q;
    buf_d   = buf_q;
    pick    = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;

    if (boundary) begin
      pick = 1'b1;
      if (state_q == SYNC && sym_q != SYNC_SYMS) begin
        pick  = 1'b0;
        sym_d = sym_q + 3'd1;
      end else if (state_q == DATA && sym_q != DATA_SYMS) begin
        pick  = 1'b0;
        sym_d = sym_q + 3'd1;
        shift = 1'b1;
      end
      if (pick) begin
        if (full_q) begin
          state_d = DATA;
          sym_d   = 3'd1;
          load    = 1'b1;
          full_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    end else if (state_q == DATA) begin
      shift = 1'b1;
    end

    // Accept needs an empty buffer and load needs a full one, so they never
    // collide on the same edge.
    if (accept) begin
      full_d = 1'b1;
      buf_d  = data_in;
    end

    active_d = (state_d == DATA);
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q  <= SYNC;
      cnt_q    <= 3'd0;
      sym_q    <= 3'd0;
      full_q   <= 1'b0;
      buf_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sym_q    <= sym_d;
      full_q   <= full_d;
      buf_q    <= buf_d;
      active_q <= active_d;
    end
  end

  phy_tx_lane u_lane0 (
    .clk_i     (clk_32f),
    .rst_ni    (reset),
    .load_i    (load),
    .shift_i   (shift),
    .word_i    ({buf_q[31:24], buf_q[15:8]}),
    .com_bit_i (com_bit),
    .ser_o     (data_out_0)
  );

  phy_tx_lane u_lane1 (
    .clk_i     (clk_32f),
    .rst_ni    (reset),
    .load_i    (load),
    .shift_i   (shift),
    .word_i    ({buf_q[23:16], buf_q[7:0]}),
    .com_bit_i (com_bit),
    .ser_o     (data_out_1)
  );

  assign active = active_q;

endmodule

// File: tb/tb_phy_tx.sv
// Bench for phy_tx. The reference model works at schedule level: a word
// accepted at edge a starts at the first multiple of 8 that is >= a+1, >= 32
// and >= the end of the word in flight; outside payload the lanes carry COM.
module tb_phy_tx;

  logic        clk_32f = 1'b0;
  logic        reset   = 1'b0;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready, data_out_0, data_out_1, active;

  int total = 0;
  int bad   = 0;

  phy_tx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready      (ready),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .active     (active)
  );

  always #5 clk_32f = ~clk_32f;

  // reference model state
  int          e;          // edge index since reset release
  bit          m_full;
  logic [31:0] m_buf;
  int          m_pend;     // start edge of the buffered word
  int          cur_start;
  logic [31:0] cur_word;
  int          m_nacc;
  bit          exp_l0, exp_l1, exp_act, exp_rdy;

  function automatic int round8(input int x);
    return ((x + 7) / 8) * 8;
  endfunction

  task automatic model_reset();
    e = -1; m_full = 0; m_pend = 0; cur_start = -1000; cur_word = '0; m_nacc = 0;
  endtask

  // Called at a negedge with reset high; returns at the following negedge.
  task automatic step(input bit v, input logic [31:0] d);
    bit acc;
    logic [15:0] w0, w1;
    logic [7:0] com;
    int k;
    valid_in = v;
    data_in  = d;
    acc = v && !m_full;
    @(posedge clk_32f);
    e++;
    if (m_full && e == m_pend) begin
      cur_start = e; cur_word = m_buf; m_full = 0;
    end
    if (acc) begin
      m_full = 1; m_buf = d; m_nacc++;
      m_pend = round8(e + 1);
      if (m_pend < 32) m_pend = 32;
      if (m_pend < cur_start + 16) m_pend = cur_start + 16;
    end
    com = 8'hBC;
    if (e >= cur_start && e < cur_start + 16) begin
      k  = e - cur_start;
      w0 = {cur_word[31:24], cur_word[15:8]};
      w1 = {cur_word[23:16], cur_word[7:0]};
      exp_l0 = w0[15-k]; exp_l1 = w1[15-k]; exp_act = 1;
    end else begin
      exp_l0 = com[7 - (e % 8)]; exp_l1 = exp_l0; exp_act = 0;
    end
    exp_rdy = !m_full;
    @(negedge clk_32f);
  endtask

  task automatic hold_reset(input int n);
    reset = 0; valid_in = 0; data_in = '0;
    repeat (n) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 0; valid_in = 1; data_in = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_32f);
      @(negedge clk_32f);
      total++;
      if ({data_out_0, data_out_1, active, ready} !== 4'b0000) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%b exp=0000", i, {data_out_0, data_out_1, active, ready});
      end
    end
  endtask

  task automatic test_idle_com();
    hold_reset(2);
    for (int i = 0; i < 64; i++) begin
      step(0, $urandom);
      total++;
      if ({data_out_0, data_out_1, active, ready} !== {exp_l0, exp_l1, exp_act, exp_rdy}) begin
        bad++;
        $display("FAIL idle_com edge=%0d got=%b exp=%b", e,
                 {data_out_0, data_out_1, active, ready}, {exp_l0, exp_l1, exp_act, exp_rdy});
      end
    end
  endtask

  task automatic test_single();
    int first_act = -1, n_act = 0;
    hold_reset(2);
    for (int i = 0; i < 72; i++) begin
      step(e + 1 == 5, 32'hA5C30FF0);
      if (active) begin n_act++; if (first_act < 0) first_act = e; end
      total++;
      if ({data_out_0, data_out_1, active, ready} !== {exp_l0, exp_l1, exp_act, exp_rdy}) begin
        bad++;
        $display("FAIL single edge=%0d got=%b exp=%b", e,
                 {data_out_0, data_out_1, active, ready}, {exp_l0, exp_l1, exp_act, exp_rdy});
      end
    end
    total++;
    if (first_act !== 32 || n_act !== 16) begin
      bad++;
      $display("FAIL single_window first=%0d n=%0d exp first=32 n=16", first_act, n_act);
    end
  endtask

  task automatic test_back_to_back();
    int first_act = -1, last_act = -1, n_act = 0;
    hold_reset(2);
    for (int i = 0; i < 80; i++) begin
      if (m_nacc == 0)      step(1, 32'h11223344);
      else if (m_nacc == 1) step(1, 32'h55667788);
      else                  step(0, '0);
      if (active) begin n_act++; last_act = e; if (first_act < 0) first_act = e; end
      total++;
      if ({data_out_0, data_out_1, active, ready} !== {exp_l0, exp_l1, exp_act, exp_rdy}) begin
        bad++;
        $display("FAIL b2b edge=%0d got=%b exp=%b", e,
                 {data_out_0, data_out_1, active, ready}, {exp_l0, exp_l1, exp_act, exp_rdy});
      end
    end
    total++;
    if (first_act !== 32 || last_act !== 63 || n_act !== 32) begin
      bad++;
      $display("FAIL b2b_window first=%0d last=%0d n=%0d exp 32 63 32", first_act, last_act, n_act);
    end
  endtask

  task automatic test_mid_idle();
    int first_act = -1;
    hold_reset(2);
    for (int i = 0; i < 80; i++) begin
      step(e + 1 == 50, 32'h3C96F00D);
      if (active && first_act < 0) first_act = e;
      total++;
      if ({data_out_0, data_out_1, active, ready} !== {exp_l0, exp_l1, exp_act, exp_rdy}) begin
        bad++;
        $display("FAIL mid_idle edge=%0d got=%b exp=%b", e,
                 {data_out_0, data_out_1, active, ready}, {exp_l0, exp_l1, exp_act, exp_rdy});
      end
    end
    total++;
    if (first_act !== 56) begin
      bad++;
      $display("FAIL mid_idle_start got=%0d exp=56", first_act);
    end
  endtask

  task automatic test_reset_mid_word();
    int n_act = 0;
    hold_reset(2);
    for (int i = 0; i < 40; i++) step(e + 1 == 3, 32'hCAFEF00D);
    // edge 40 lands in the middle of the payload
    reset = 0; valid_in = 1; data_in = 32'h12345678;
    @(posedge clk_32f);
    @(negedge clk_32f);
    total++;
    if ({data_out_0, data_out_1, active, ready} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid got=%b exp=0000", {data_out_0, data_out_1, active, ready});
    end
    hold_reset(1);
    for (int i = 0; i < 72; i++) begin
      step(0, '0);
      if (active) n_act++;
      total++;
      if ({data_out_0, data_out_1, active, ready} !== {exp_l0, exp_l1, exp_act, exp_rdy}) begin
        bad++;
        $display("FAIL reset_resync edge=%0d got=%b exp=%b", e,
                 {data_out_0, data_out_1, active, ready}, {exp_l0, exp_l1, exp_act, exp_rdy});
      end
    end
    total++;
    if (n_act !== 0) begin
      bad++;
      $display("FAIL reset_dropped active_cycles=%0d exp=0", n_act);
    end
  endtask

  task automatic test_random();
    hold_reset(3);
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 3) == 0, $urandom);
      total++;
      if ({data_out_0, data_out_1, active, ready} !== {exp_l0, exp_l1, exp_act, exp_rdy}) begin
        bad++;
        $display("FAIL random edge=%0d got=%b exp=%b", e,
                 {data_out_0, data_out_1, active, ready}, {exp_l0, exp_l1, exp_act, exp_rdy});
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk_32f);
    test_reset();
    test_idle_com();
    test_single();
    test_back_to_back();
    test_mid_idle();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
